call_queue: RTL

Floor-call request manager that sits directly upstream of the elevator control FSM. It debounces the raw per-floor call buttons and latches each accepted press as a pending request. It supplies the FSM with `input_bool`, which says whether any request is pending, and with the destination floor chosen by a SCAN (same-direction-first) policy. When the FSM signals that a destination has been served, the block clears that request.

---
 rtl/elev_pkg.sv | 34 +++
 rtl/call_queue_if.sv | 23 ++
 rtl/btn_debounce.sv | 100 ++++++++++
 rtl/call_queue.sv | 100 ++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared elevator definitions: default floor width, direction and comparator
// codes, and the debounce state encoding.
package elev_pkg;

    localparam int FLOOR_W_DFLT = 3;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        DB_IDLE    = 2'd0,
        DB_WAIT_HI = 2'd1,
        DB_HELD    = 2'd2,
        DB_WAIT_LO = 2'd3
    } db_state_e;

    // One-hot magnitude comparison of two floor indices.
    function automatic logic [2:0] cmp_code(input logic [15:0] a, input logic [15:0] b);
        logic [2:0] code;
        if (a > b) begin
            code = CMP_GT;
        end else if (a == b) begin
            code = CMP_EQ;
        end else begin
            code = CMP_LT;
        end
        return code;
    endfunction

endpackage

// File: rtl/call_queue_if.sv
// Handshake between the call queue and the elevator control FSM.
interface call_queue_if #(
    parameter int FLOOR_W = 3
);
    logic               input_en;
    logic               rst_des_en;
    logic [FLOOR_W-1:0] cur_floor;
    logic               dir_up;
    logic               input_bool;
    logic [FLOOR_W-1:0] des_floor;

    // Control FSM side.
    modport master (
        output input_en, rst_des_en, cur_floor, dir_up,
        input  input_bool, des_floor
    );

    // Call queue side.
    modport slave (
        input  input_en, rst_des_en, cur_floor, dir_up,
        output input_bool, des_floor
    );
endinterface

// File: rtl/btn_debounce.sv
// One call button: two-flop synchronizer followed by a four-state debounce
// FSM. press pulses for one cycle only when a rising level is qualified.
module btn_debounce
    import elev_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic irst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic            sync1_r;
    logic            sync2_r;
    db_state_e       state_r;
    db_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Debounce state and stable-cycle counter registers.
    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            state_r <= DB_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; the press pulse fires only on WAIT_HI -> HELD.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        press   = 1'b0;
        case (state_r)
            DB_IDLE: begin
                if (sync2_r) begin
                    state_s = DB_WAIT_HI;
                    cnt_s   = '0;
                end else begin
                    state_s = DB_IDLE;
                    cnt_s   = '0;
                end
            end
            DB_WAIT_HI: begin
                if (!sync2_r) begin
                    state_s = DB_IDLE;
                    cnt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = DB_HELD;
                    cnt_s   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_s   = cnt_r + 1'b1;
                end
            end
            DB_HELD: begin
                if (!sync2_r) begin
                    state_s = DB_WAIT_LO;
                    cnt_s   = '0;
                end else begin
                    state_s = DB_HELD;
                    cnt_s   = '0;
                end
            end
            DB_WAIT_LO: begin
                if (sync2_r) begin
                    state_s = DB_HELD;
                    cnt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = DB_IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = DB_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

endmodule

// File: rtl/call_queue.sv
// Floor-call request manager: debounces call buttons, latches pending
// requests and picks the next destination with a SCAN policy.
module call_queue
    import elev_pkg::*;
#(
    parameter int FLOORS       = 8,
    parameter int FLOOR_W      = FLOOR_W_DFLT,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic              clk,
    input  logic              irst_n,
    input  logic [FLOORS-1:0] btn,
    output logic [FLOORS-1:0] pending,
    call_queue_if.slave       fsm
);

    logic [FLOORS-1:0]  press_s;
    logic [FLOORS-1:0]  pending_r;
    logic [FLOORS-1:0]  pending_nxt_s;
    logic [FLOORS-1:0]  clr_mask_s;
    logic               input_bool_r;
    logic [FLOOR_W-1:0] des_floor_r;
    logic [FLOOR_W-1:0] cur_eff_s;
    logic [FLOOR_W-1:0] sel_s;
    logic [FLOOR_W-1:0] up_sel_s;
    logic [FLOOR_W-1:0] up_fb_s;
    logic [FLOOR_W-1:0] dn_sel_s;
    logic [FLOOR_W-1:0] dn_fb_s;
    logic               up_hit_s;
    logic               dn_hit_s;
    logic               dn_fb_hit_s;

    for (genvar g = 0; g < FLOORS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk   (clk),
            .irst_n(irst_n),
            .btn   (btn[g]),
            .press (press_s[g])
        );
    end

    // An out-of-range current floor is treated as the top floor.
    assign cur_eff_s = (32'(fsm.cur_floor) >= FLOORS) ? FLOOR_W'(FLOORS - 1) : fsm.cur_floor;

    // SCAN selection: ascending scan gives first-hit (lowest) and last-hit
    // (highest) candidates on each side of the current floor.
    always_comb begin
        up_hit_s    = 1'b0;
        up_sel_s    = '0;
        up_fb_s     = '0;
        dn_hit_s    = 1'b0;
        dn_sel_s    = '0;
        dn_fb_hit_s = 1'b0;
        dn_fb_s     = '0;
        for (int i = 0; i < FLOORS; i++) begin
            up_sel_s    = (pending_r[i] && !up_hit_s && (cmp_code(16'(i), 16'(cur_eff_s)) != CMP_LT))
                          ? FLOOR_W'(i) : up_sel_s;
            up_hit_s    = up_hit_s | (pending_r[i] && (cmp_code(16'(i), 16'(cur_eff_s)) != CMP_LT));
            up_fb_s     = (pending_r[i] && (cmp_code(16'(i), 16'(cur_eff_s)) == CMP_LT))
                          ? FLOOR_W'(i) : up_fb_s;
            dn_sel_s    = (pending_r[i] && (cmp_code(16'(i), 16'(cur_eff_s)) != CMP_GT))
                          ? FLOOR_W'(i) : dn_sel_s;
            dn_hit_s    = dn_hit_s | (pending_r[i] && (cmp_code(16'(i), 16'(cur_eff_s)) != CMP_GT));
            dn_fb_s     = (pending_r[i] && !dn_fb_hit_s && (cmp_code(16'(i), 16'(cur_eff_s)) == CMP_GT))
                          ? FLOOR_W'(i) : dn_fb_s;
            dn_fb_hit_s = dn_fb_hit_s | (pending_r[i] && (cmp_code(16'(i), 16'(cur_eff_s)) == CMP_GT));
        end
        sel_s = (~|pending_r)           ? des_floor_r :
                (fsm.dir_up == DIR_UP)  ? (up_hit_s ? up_sel_s : up_fb_s) :
                                          (dn_hit_s ? dn_sel_s : dn_fb_s);
    end

    // Serving clears the old destination; clear beats a same-cycle set.
    assign clr_mask_s    = fsm.rst_des_en ? ({{(FLOORS-1){1'b0}}, 1'b1} << des_floor_r) : '0;
    assign pending_nxt_s = (pending_r | press_s) & ~clr_mask_s;

    // Request bits, any-pending flag and destination registers.
    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            pending_r    <= '0;
            input_bool_r <= 1'b0;
            des_floor_r  <= '0;
        end else begin
            pending_r    <= pending_nxt_s;
            input_bool_r <= |pending_nxt_s;
            if (fsm.input_en) begin
                des_floor_r <= sel_s;
            end else begin
                des_floor_r <= des_floor_r;
            end
        end
    end

    assign pending        = pending_r;
    assign fsm.input_bool = input_bool_r;
    assign fsm.des_floor  = des_floor_r;

endmodule
